spi_slave: RTL and testbench
============================

# spi_slave

SPI responder that serves the target side of the link driven by the team's `spi` master. It oversamples `sclk`, `ss_n` and `mosi` in the system clock domain and supports all four CPOL/CPHA modes with MSB-first 8-bit words. Each received byte is presented on `rx_data` with a one-cycle `rx_valid` strobe. Each transmitted byte comes from a one-entry TX holding buffer, so several bytes can be sent back-to-back within one `ss_n` frame.

## Interface
Clocking is fixed: one clock, `clk`, on the rising edge. `reset` is asynchronous and active-low.

Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each of `sclk`, `ss_n`, `mosi`; must be ≥2.
- `DW`, default 8: word width in bits.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cpol`  in  1  idle level of `sclk`; static while `ss_n` = 1.
- `cpha`  in  1  0 = sample on leading edge, 1 = sample on trailing edge; static while `ss_n` = 1.
- `sclk`  in  1  SPI clock from master (asynchronous).
- `ss_n`  in  1  target select, active-low (asynchronous).
- `mosi`  in  1  serial data in.
- `miso`  out  1  serial data out.
- `miso_oe`  out  1  output enable for the pad tri-state.
- `tx_data`  in  DW  byte to transmit.
- `tx_wr`  in  1  write `tx_data` into the TX buffer.
- `tx_ready`  out  1  TX buffer empty.
- `rx_data`  out  DW  last completed received byte.
- `rx_valid`  out  1  one-cycle strobe when `rx_data` updates.
- `tx_underrun`  out  1  one-cycle strobe: a word was loaded while the buffer was empty.
- `busy`  out  1  frame active.

## Operation
- **Synchronisation:** the three inputs pass through `SYNC_STAGES` flip-flops. Edges are detected by comparing the synced `sclk` with its one-cycle-delayed copy.
- **Edge definitions:** leading edge = transition away from `cpol`; trailing edge = transition back to `cpol`. The sample edge is the leading edge when `cpha` = 0 and the trailing edge when `cpha` = 1. The shift edge is the other one.
- **FSM states:** IDLE and ACTIVE.
- **IDLE → ACTIVE:** on a synced `ss_n` falling edge.
  - Load the shift register from the TX buffer and set `tx_ready` = 1.
  - If the buffer is empty, load 0x00 and pulse `tx_underrun`.
  - Clear the bit counter and set `miso_oe` = 1.
- **ACTIVE, `miso` driving:**
  - `cpha` = 0: `miso` = shift MSB from load onward; each shift edge advances one bit.
  - `cpha` = 1: the first leading edge presents the MSB; each later shift edge advances one bit.
- **ACTIVE, sampling:** each sample edge shifts `mosi` into the RX register and increments the bit counter (0..DW-1, wraps).
- **Word completion (counter wraps):**
  - `rx_data` ← assembled byte; pulse `rx_valid`.
  - Reload the shift register from the TX buffer, applying the same underrun rule.
- **ACTIVE → IDLE:** on a synced `ss_n` rising edge.
  - Any partial word is discarded, with no `rx_valid`.
  - `miso_oe` = 0 and `busy` = 0.
  - The TX byte consumed by that partial word is lost.
- **TX buffer writes:**
  - `tx_wr` while `tx_ready` = 0 is ignored (no overwrite).
  - `tx_wr` in the same cycle as a load: the load sees the pre-write state, i.e. empty → 0x00 plus underrun. The written byte is kept for the next word.
- **`rx_valid`:** not back-pressured; the consumer must capture it in that cycle.

## Timing
- **Reset values:** `miso` = 0, `miso_oe` = 0, `tx_ready` = 1, `rx_data` = 0x00, `rx_valid` = 0, `tx_underrun` = 0, `busy` = 0, FSM = IDLE. Synchronizer flops reset to `sclk` = `cpol`, `ss_n` = 1, `mosi` = 0.
- **Reset mid-frame:** all state clears immediately; no strobe is issued.
- **Edge detection:** an `sclk` edge acts SYNC_STAGES+1 `clk` rising edges after the first `clk` edge that samples the new pin level.
- **`rx_valid`:** high for exactly one cycle, on the cycle the 8th sample edge is acted on.
- **`ss_n` fall to `miso_oe`:** SYNC_STAGES+1 cycles.
- **Frequency limit:** f_sclk ≤ f_clk/8. The master must hold `ss_n` low ≥4 `clk` cycles before the first leading edge, so that `miso` is valid in `cpha` = 0 modes.

## Structure
- Package `spi_pkg`:
  - `state_t` enum with IDLE and ACTIVE.
  - `spi_mode_t` (`cpol`, `cpha`) struct.
  - Constant `SPI_DW` = 8.
- Sub-module `sync_edge`: parameterised N-stage synchronizer with rise/fall outputs. Instantiated for `sclk` and `ss_n`; `mosi` uses a plain synchronizer only.

## Test plan
- **Mode 3, single byte:** preload TX 0xA5; master sends 0xC1 → `rx_data` = 0xC1 with one `rx_valid` pulse; master receives 0xA5; `tx_ready` = 1 after load.
- **Mode 0, three bytes in one frame:** master sends 0xC1, 0xBE, 0xEF; TX preloads 0x11, 0x22, 0x33, each written during the prior word → three `rx_valid` pulses with 0xC1/0xBE/0xEF; master receives 0x11/0x22/0x33; no underrun.
- **Underrun, mode 1:** buffer empty at `ss_n` fall → `miso` shifts 0x00 and `tx_underrun` pulses once; a `tx_wr` of 0x5A in the load cycle is sent on the next word.
- **Abort, mode 2:** `ss_n` rises after 5 bits → no `rx_valid`, `rx_data` unchanged, `miso_oe` = 0, `busy` = 0. The next frame sending 0x3C is received correctly.
- **Reset mid-frame:** assert `reset` after 3 bits → all outputs at reset values immediately. After release, a mode 3 transfer of 0x96 succeeds.
- **Ignored write:** `tx_wr` 0x77 while `tx_ready` = 0 → buffer keeps the earlier 0x44, and the master receives 0x44.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

  localparam int SPI_DW = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with rise/fall pulses taken
// from the synced level against its one-cycle-delayed copy.
module sync_edge #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync_q;
  logic         q_d;

  // reset level is the pin's idle level so release does not fake an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {N{rst_val}};
      q_d    <= rst_val;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
      q_d    <= sync_q[N-1];
    end
  end

  assign rise = sync_q[N-1] & ~q_d;
  assign fall = ~sync_q[N-1] & q_d;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, all four CPOL/CPHA modes, MSB first, oversampled in clk.
//   state  | meaning
//   IDLE   | ss_n deasserted, miso tri-stated, sclk edges ignored
//   ACTIVE | frame in progress, shifting words in and out
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = SPI_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          sclk,
  input  logic          ss_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_wr,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          tx_underrun,
  output logic          busy
);

  localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  spi_mode_t              mode;
  state_t                 state, state_nx;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   active, start, sample, word_done, load;
  logic [DW-1:0]          tx_buf, tx_sh, rx_next;
  logic [DW-2:0]          rx_sh;
  logic                   tx_full, skip;
  logic [CW-1:0]          bit_cnt;

  assign mode = '{cpol: cpol, cpha: cpha};

  sync_edge #(.N(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .rst_val(mode.cpol), .d(sclk),
    .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.N(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .reset(reset), .rst_val(1'b1), .d(ss_n),
    .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign lead_edge   = mode.cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = mode.cpol ? sclk_rise : sclk_fall;
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode.cpha ? lead_edge : trail_edge;

  assign active    = (state == ACTIVE);
  assign start     = !active && ss_fall;
  assign sample    = active && !ss_rise && sample_edge;
  assign word_done = sample && (bit_cnt == LAST_BIT);
  assign load      = start || word_done;
  assign rx_next   = {rx_sh, mosi_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ss_fall) state_nx = ACTIVE;
      ACTIVE:  if (ss_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // skip swallows the first shift edge after a load: in cpha=1 that edge only
  // presents the MSB, in cpha=0 it is the trailing edge of the word just done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      skip        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (tx_wr && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end
      if (load) begin
        if (tx_full) begin
          tx_sh   <= tx_buf;
          tx_full <= 1'b0;
        end else begin
          tx_sh       <= '0;
          tx_underrun <= 1'b1;
        end
        skip <= mode.cpha | word_done;
      end else if (active && !ss_rise && shift_edge) begin
        if (skip) skip  <= 1'b0;
        else      tx_sh <= {tx_sh[DW-2:0], 1'b0};
      end
      if (start) bit_cnt <= '0;
      if (sample) begin
        rx_sh   <= rx_next[DW-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  assign miso     = active & tx_sh[DW-1];
  assign miso_oe  = active;
  assign busy     = active;
  assign tx_ready = ~tx_full;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bench-driven SPI master plus a transaction-level
// model of the TX holding buffer and the expected received words.
module tb_spi_slave;

  localparam int H = 8;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, sclk, ss_n, mosi;
  logic       miso, miso_oe, tx_wr, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  spi_slave #(.SYNC_STAGES(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sclk(sclk),
    .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic       m_full;
  logic [7:0] m_buf;
  logic [7:0] m_rx_last;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         exp_ur = 0;
  int         dut_ur = 0;
  int         dut_rxv = 0;

  // stimulus for one frame
  logic [7:0] mq[$];
  logic [8:0] wr_sched[$];
  logic [7:0] rcv[$];
  logic       ready_mid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic void model_load();
    if (m_full) begin
      exp_tx.push_back(m_buf);
      m_full = 1'b0;
    end else begin
      exp_tx.push_back(8'h00);
      exp_ur++;
    end
  endfunction

  task automatic half();
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    chk("tx_ready", 32'(tx_ready), 32'(!m_full));
    tx_data = d;
    tx_wr   = 1'b1;
    @(posedge clk);
    #1 tx_wr = 1'b0;
    if (!m_full) begin
      m_buf  = d;
      m_full = 1'b1;
    end
  endtask

  task automatic word_end(input logic [7:0] sent, input logic [7:0] got);
    rcv.push_back(got);
    chk("miso_byte", 32'(got), 32'(exp_tx.pop_front()));
    exp_rx.push_back(sent);
    model_load();
  endtask

  task automatic run_frame(input bit p, input bit h, input int nbits, input int rst_at,
                           input bit wr_at_load, input logic [7:0] wl_data);
    logic [7:0] rxb;
    logic       pre;
    rcv.delete();
    rxb  = 8'h00;
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (6) @(posedge clk);
    #1 ss_n = 1'b0;
    if (wr_at_load) begin
      @(posedge clk);
      @(posedge clk);
      #1 chk("busy_before_load", 32'(busy), 32'h0);
      tx_data = wl_data;
      tx_wr   = 1'b1;
      pre     = m_full;
      model_load();
      if (!pre) begin
        m_buf  = wl_data;
        m_full = 1'b1;
      end
      @(posedge clk);
      #1 tx_wr = 1'b0;
      chk("busy_at_load", 32'(busy), 32'h1);
      half();
    end else begin
      model_load();
      repeat (10) @(posedge clk);
      #1;
    end
    for (int b = 0; b < nbits; b++) begin
      int         w;
      int         i;
      logic [7:0] d;
      w = b / 8;
      i = b % 8;
      d = mq[w];
      if (b == rst_at) begin
        reset = 1'b0;
        ss_n  = 1'b1;
        sclk  = p;
        mosi  = 1'b0;
        #1;
        chk("rst_miso", 32'(miso), 32'h0);
        chk("rst_miso_oe", 32'(miso_oe), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'h1);
        chk("rst_rx_data", 32'(rx_data), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("rst_tx_underrun", 32'(tx_underrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        m_full    = 1'b0;
        m_rx_last = 8'h00;
        exp_tx.delete();
        exp_rx.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      if (i == 2 && w < wr_sched.size() && wr_sched[w][8]) do_write(wr_sched[w][7:0]);
      if (i == 4 && b < 8) ready_mid = tx_ready;
      if (!h) begin
        mosi = d[7-i];
        half();
        sclk = ~p;
        rxb[7-i] = miso;
        if (i == 7) word_end(d, rxb);
        half();
        sclk = p;
      end else begin
        sclk = ~p;
        mosi = d[7-i];
        half();
        sclk = p;
        rxb[7-i] = miso;
        if (i == 7) word_end(d, rxb);
        half();
      end
    end
    if (!h) half();
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rx_pending", 32'(exp_rx.size()), 32'h0);
    chk("underruns", 32'(dut_ur), 32'(exp_ur));
    exp_tx.delete();
  endtask

  // per-cycle compare against the model
  initial begin
    int   stab;
    logic prev_ss;
    stab    = 0;
    prev_ss = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        stab    = 0;
        prev_ss = ss_n;
      end else begin
        if (ss_n !== prev_ss) stab = 0;
        else if (stab < 100) stab++;
        prev_ss = ss_n;
        if (tx_underrun) dut_ur++;
        if (rx_valid) begin
          dut_rxv++;
          if (exp_rx.size() == 0) chk("unexpected_rx_valid", 32'(rx_valid), 32'h0);
          else begin
            m_rx_last = exp_rx.pop_front();
            chk("rx_data", 32'(rx_data), 32'(m_rx_last));
          end
        end else chk("rx_hold", 32'(rx_data), 32'(m_rx_last));
        if (stab >= 5) begin
          chk("busy", 32'(busy), 32'(!ss_n));
          chk("miso_oe", 32'(miso_oe), 32'(!ss_n));
        end
        if (!busy) chk("miso_idle", 32'(miso), 32'h0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int ur0;
    int rv0;
    reset = 1'b0; cpol = 1'b1; cpha = 1'b1; sclk = 1'b1; ss_n = 1'b1;
    mosi = 1'b0; tx_data = 8'h00; tx_wr = 1'b0;
    m_full = 1'b0; m_buf = 8'h00; m_rx_last = 8'h00; ready_mid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", 32'(miso), 32'h0);
    chk("reset_miso_oe", 32'(miso_oe), 32'h0);
    chk("reset_tx_ready", 32'(tx_ready), 32'h1);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // mode 3, single byte
    do_write(8'hA5);
    mq = '{8'hC1}; wr_sched = '{9'h000};
    rv0 = dut_rxv;
    run_frame(1'b1, 1'b1, 8, -1, 1'b0, 8'h00);
    chk("t1_miso", 32'(rcv[0]), 32'hA5);
    chk("t1_rx_data", 32'(rx_data), 32'hC1);
    chk("t1_rx_pulses", 32'(dut_rxv - rv0), 32'h1);
    chk("t1_tx_ready", 32'(ready_mid), 32'h1);

    // mode 0, three bytes back to back
    do_write(8'h11);
    mq = '{8'hC1, 8'hBE, 8'hEF}; wr_sched = '{9'h122, 9'h133, 9'h199};
    rv0 = dut_rxv; ur0 = dut_ur;
    run_frame(1'b0, 1'b0, 24, -1, 1'b0, 8'h00);
    chk("t2_miso0", 32'(rcv[0]), 32'h11);
    chk("t2_miso1", 32'(rcv[1]), 32'h22);
    chk("t2_miso2", 32'(rcv[2]), 32'h33);
    chk("t2_rx_pulses", 32'(dut_rxv - rv0), 32'h3);
    chk("t2_underruns", 32'(dut_ur - ur0), 32'h0);
    chk("t2_rx_data", 32'(rx_data), 32'hEF);

    // mode 1, underrun with a write in the load cycle
    mq = '{8'h12, 8'h34}; wr_sched = '{9'h000, 9'h166};
    ur0 = dut_ur;
    run_frame(1'b0, 1'b1, 16, -1, 1'b1, 8'h5A);
    chk("t3_miso0", 32'(rcv[0]), 32'h00);
    chk("t3_miso1", 32'(rcv[1]), 32'h5A);
    chk("t3_underruns", 32'(dut_ur - ur0), 32'h1);

    // mode 2, abort after 5 bits, then a clean frame
    do_write(8'h21);
    mq = '{8'hF0}; wr_sched = '{9'h000};
    rv0 = dut_rxv;
    run_frame(1'b1, 1'b0, 5, -1, 1'b0, 8'h00);
    chk("t4_no_rx_valid", 32'(dut_rxv - rv0), 32'h0);
    chk("t4_rx_data_kept", 32'(rx_data), 32'h34);
    chk("t4_miso_oe", 32'(miso_oe), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    mq = '{8'h3C};
    run_frame(1'b1, 1'b0, 8, -1, 1'b0, 8'h00);
    chk("t4_rx_next", 32'(rx_data), 32'h3C);

    // reset after 3 bits, then a mode 3 transfer
    do_write(8'h70);
    mq = '{8'hAA};
    run_frame(1'b1, 1'b1, 8, 3, 1'b0, 8'h00);
    do_write(8'h5C);
    mq = '{8'h96};
    run_frame(1'b1, 1'b1, 8, -1, 1'b0, 8'h00);
    chk("t5_rx_data", 32'(rx_data), 32'h96);
    chk("t5_miso", 32'(rcv[0]), 32'h5C);

    // write while full is ignored
    do_write(8'h44);
    chk("t6_ready_low", 32'(tx_ready), 32'h0);
    do_write(8'h77);
    mq = '{8'h0F};
    run_frame(1'b0, 1'b0, 8, -1, 1'b0, 8'h00);
    chk("t6_miso", 32'(rcv[0]), 32'h44);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      int nw;
      int nb;
      bit p;
      bit h;
      bit wl;
      p  = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      wl = ($urandom_range(0, 3) == 0);
      nw = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 255)));
      mq.delete();
      wr_sched.delete();
      for (int j = 0; j < nw; j++) begin
        mq.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 9) < 6) wr_sched.push_back({1'b1, 8'($urandom_range(0, 255))});
        else wr_sched.push_back(9'h000);
      end
      nb = nw * 8;
      if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, nw * 8 - 1);
      run_frame(p, h, nb, -1, wl, 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
